// File: rtl/cas_rec_pkg.sv
// Shared types and constants for the Sord M5 cassette recorder.
package cas_rec_pkg;

  localparam int unsigned PeriodW = 18;
  localparam int unsigned HdrLen  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StLeader,
    StSync,
    StData,
    StStop
  } rec_state_e;

  // CAS header: "SORDM5" followed by ten zero bytes.
  localparam logic [7:0] HdrBytes [HdrLen] = '{
    8'h53, 8'h4F, 8'h52, 8'h44, 8'h4D, 8'h35, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] hdr_byte(input logic [3:0] idx);
    return HdrBytes[idx];
  endfunction

endpackage

// File: rtl/cas_rec_period_meter.sv
// Synchronises the tape line, measures rising-edge periods and classifies FSK bits.
module cas_rec_period_meter
  import cas_rec_pkg::*;
#(
  parameter int unsigned BIT_THRESH = 14222,
  parameter int unsigned GAP_CYCLES = 213333
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic tape_i,
  output logic bit_o,
  output logic bit_valid_o,
  output logic gap_o
);

  localparam logic [PeriodW-1:0] ThrCnt = PeriodW'(BIT_THRESH);
  localparam logic [PeriodW-1:0] GapCnt = PeriodW'(GAP_CYCLES);

  logic               meta_q, meta_d;
  logic               sync_q, sync_d;
  logic               prev_q, prev_d;
  logic [PeriodW-1:0] cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               rise;

  always_comb begin
    meta_d  = tape_i;
    sync_d  = meta_q;
    prev_d  = sync_q;
    rise    = sync_q & ~prev_q;
    gap_o   = ~rise && (cnt_q == GapCnt - 1'b1);
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (rise) begin
      cnt_d   = {{(PeriodW-1){1'b0}}, 1'b1};
      valid_d = 1'b1;
    end else if (cnt_q != GapCnt) begin
      cnt_d = cnt_q + 1'b1;
    end
    // The period ending at the first edge after a gap (or reset) is meaningless.
    if (gap_o) valid_d = 1'b0;
    bit_valid_o = rise & valid_q;
    bit_o       = cnt_q < ThrCnt;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/cas_recorder.sv
// Sord M5 tape-out recorder: frames FSK bits into bytes and buffers them for the HPS.
// Define CAS_RECORDER_HEADER_EN to prepend a 16-byte CAS header on each arm.
module cas_recorder
  import cas_rec_pkg::*;
#(
  parameter int unsigned CLK_RATE    = 42666666,
  parameter int unsigned BIT_THRESH  = CLK_RATE / 3000,
  parameter int unsigned GAP_CYCLES  = CLK_RATE / 200,
  parameter int unsigned LEADER_BITS = 64,
  parameter int unsigned ADDR_W      = 15
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              tape_out_i,
  input  logic              arm_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [7:0]        rd_data_o,
  output logic [ADDR_W:0]   byte_count_o,
  output logic              recording_o,
  output logic              overflow_o,
  output logic              frame_err_o
);

  localparam int unsigned      LeadW    = $clog2(LEADER_BITS + 1);
  localparam logic [LeadW-1:0] LeadLast = LeadW'(LEADER_BITS - 1);

  logic bit_val, bit_valid, gap;

  cas_rec_period_meter #(
    .BIT_THRESH (BIT_THRESH),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_meter (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .tape_i      (tape_out_i),
    .bit_o       (bit_val),
    .bit_valid_o (bit_valid),
    .gap_o       (gap)
  );

  rec_state_e       state_q, state_d;
  logic [LeadW-1:0] lead_q, lead_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [ADDR_W:0]  count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             ferr_q, ferr_d;
  logic             arm_q, arm_d;
  logic [7:0]       rd_data_q, rd_data_d;
`ifdef CAS_RECORDER_HEADER_EN
  logic [3:0]       hdr_q, hdr_d;
`endif

  logic       push;
  logic [7:0] push_data;
  logic       we;
  logic [7:0] mem [2**ADDR_W];

  always_comb begin
    state_d   = state_q;
    lead_d    = lead_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    ferr_d    = ferr_q;
    arm_d     = arm_i;
    push      = 1'b0;
    push_data = shreg_q;
    we        = 1'b0;
`ifdef CAS_RECORDER_HEADER_EN
    hdr_d     = hdr_q;
`endif

    if (arm_i && !arm_q) begin
      count_d = '0;
      ovf_d   = 1'b0;
      ferr_d  = 1'b0;
      lead_d  = '0;
      idx_d   = '0;
`ifdef CAS_RECORDER_HEADER_EN
      state_d = StHdr;
      hdr_d   = '0;
`else
      state_d = StIdle;
`endif
    end else if (!arm_i) begin
      state_d = StIdle;
      lead_d  = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gap || (bit_valid && !bit_val)) begin
            lead_d = '0;
          end else if (bit_valid) begin
            if (lead_q == LeadLast) begin
              lead_d  = '0;
              state_d = StLeader;
            end else begin
              lead_d = lead_q + 1'b1;
            end
          end
        end
`ifdef CAS_RECORDER_HEADER_EN
        // Header bytes go out one per cycle; tape bits are ignored meanwhile.
        StHdr: begin
          push      = 1'b1;
          push_data = hdr_byte(hdr_q);
          if (hdr_q == 4'hF) state_d = StIdle;
          else               hdr_d   = hdr_q + 4'd1;
        end
`endif
        StLeader: begin
          if (gap) begin
            state_d = StIdle;
          end else if (bit_valid && !bit_val) begin
            idx_d   = '0;
            state_d = StData;
          end
        end
        StData: begin
          if (gap) begin
            state_d = StIdle;
          end else if (bit_valid) begin
            shreg_d[idx_q] = bit_val;
            if (idx_q == 3'd7) state_d = StStop;
            else               idx_d   = idx_q + 3'd1;
          end
        end
        StStop: begin
          if (gap) begin
            state_d = StIdle;
          end else if (bit_valid) begin
            push = 1'b1;
            if (bit_val) begin
              state_d = StSync;
            end else begin
              ferr_d  = 1'b1;
              state_d = StLeader;
            end
          end
        end
        StSync: begin
          if (gap) begin
            state_d = StIdle;
          end else if (bit_valid && !bit_val) begin
            idx_d   = '0;
            state_d = StData;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Top bit of the count set means the buffer is full.
    if (push) begin
      if (count_q[ADDR_W]) begin
        ovf_d = 1'b1;
      end else begin
        we      = 1'b1;
        count_d = count_q + 1'b1;
      end
    end

    rd_data_d = mem[rd_addr_i];
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      lead_q    <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
      arm_q     <= 1'b0;
      rd_data_q <= '0;
`ifdef CAS_RECORDER_HEADER_EN
      hdr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      lead_q    <= lead_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      ferr_q    <= ferr_d;
      arm_q     <= arm_d;
      rd_data_q <= rd_data_d;
`ifdef CAS_RECORDER_HEADER_EN
      hdr_q     <= hdr_d;
`endif
    end
  end

  // Plain write port; a same-cycle read of this address sees the old byte.
  always_ff @(posedge clk_i) begin
    if (we) mem[count_q[ADDR_W-1:0]] <= push_data;
  end

  always_comb begin
    rd_data_o    = rd_data_q;
    byte_count_o = count_q;
    overflow_o   = ovf_q;
    frame_err_o  = ferr_q;
    recording_o  = (state_q == StSync) || (state_q == StData) || (state_q == StStop);
  end

endmodule
